// File: rtl/io64_uart_tx.sv
// UART-style transmitter on the CPU output port: toggle-handshake request on IO64_OUT[15],
// 8N1 serialisation on TXD, status and handshake returned on IO65_IN.
module io64_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] IO64_OUT,
    output logic [15:0] IO65_IN,
    output logic        TXD
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [7:0]  count_q, count_d;
    logic        bit_done_s;

    assign bit_done_s = (baud_q == BAUD_LAST);

    // Next-state and next-output computation for the frame sequencer
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                // A request is pending whenever REQ and ACK toggles differ
                if (IO64_OUT[15] != ack_q) begin
                    shift_d = IO64_OUT[7:0];
                    state_d = START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    txd_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (bit_done_s) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    baud_d  = 16'd0;
                    state_d = IDLE;
                    ack_d   = ~ack_q;
                    busy_d  = 1'b0;
                    count_d = count_q + 8'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign TXD     = txd_q;
    assign IO65_IN = {ack_q, busy_q, 6'b000000, count_q};

endmodule

// File: tb/tb_io64_uart_tx.sv
// Self-checking bench for io64_uart_tx: frames are predicted from the 8N1 bit-list rule
// and the toggle-handshake rules, with randomized data and don't-care bits.
module tb_io64_uart_tx;

    localparam int CPB = 4;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] io64 = 16'h8055;
    logic [15:0] io65;
    logic        txd;

    int n_checks = 0;
    int n_fail   = 0;

    logic       req_m   = 1'b0;
    logic       ack_m   = 1'b0;
    logic [7:0] count_m = 8'd0;

    always #5 clk = ~clk;

    io64_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK     (clk),
        .RESET   (rst),
        .IO64_OUT(io64),
        .IO65_IN (io65),
        .TXD     (txd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the edge that should have started a frame.
    task automatic run_frame(input logic [7:0] data, input int mid_a, input logic [15:0] val_a,
                             input int mid_b, input logic [15:0] val_b);
        logic [9:0]  bits;
        logic [15:0] exp_busy;
        logic [15:0] exp_done;
        bits     = {1'b1, data, 1'b0};
        exp_busy = {ack_m, 1'b1, 6'b000000, count_m};
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i == mid_a) io64 = val_a;
            if (i == mid_b) io64 = val_b;
            n_checks++;
            if (txd !== bits[i / CPB] || io65 !== exp_busy) begin
                n_fail++;
                $display("FAIL frame_sample: byte %h sample %0d got txd=%b io65=%h expected txd=%b io65=%h",
                         data, i, txd, io65, bits[i / CPB], exp_busy);
            end
            tick();
        end
        ack_m    = ~ack_m;
        count_m  = count_m + 8'd1;
        exp_done = {ack_m, 1'b0, 6'b000000, count_m};
        n_checks++;
        if (txd !== 1'b1 || io65 !== exp_done) begin
            n_fail++;
            $display("FAIL frame_end: byte %h got txd=%b io65=%h expected txd=1 io65=%h",
                     data, txd, io65, exp_done);
        end
    endtask

    task automatic check_idle(input string name, input int cycles, input logic [15:0] exp_st);
        for (int i = 0; i < cycles; i++) begin
            tick();
            n_checks++;
            if (txd !== 1'b1 || io65 !== exp_st) begin
                n_fail++;
                $display("FAIL %s: cycle %0d got txd=%b io65=%h expected txd=1 io65=%h",
                         name, i, txd, io65, exp_st);
            end
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        io64 = 16'h0000;
        tick();
        tick();
        rst     = 1'b0;
        req_m   = 1'b0;
        ack_m   = 1'b0;
        count_m = 8'd0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (txd !== 1'b1 || io65 !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_state: cycle %0d got txd=%b io65=%h expected txd=1 io65=0000",
                         i, txd, io65);
            end
        end
        rst   = 1'b0;
        req_m = 1'b1;
        tick();
        run_frame(8'h55, 10, 16'h80AA, -1, 16'h0000);
        n_checks++;
        if (io65 !== 16'h8001) begin
            n_fail++;
            $display("FAIL first_frame_status: got %h expected 8001", io65);
        end
        check_idle("no_second_frame", 12, 16'h8001);
    endtask

    task automatic test_single_toggle();
        do_reset();
        req_m = 1'b1;
        io64  = 16'h8055;
        tick();
        run_frame(8'h55, 15, 16'h00C3, -1, 16'h0000);
        req_m = 1'b0;
        tick();
        run_frame(8'hC3, -1, 16'h0000, -1, 16'h0000);
        n_checks++;
        if (io65 !== 16'h0002) begin
            n_fail++;
            $display("FAIL single_toggle_status: got %h expected 0002", io65);
        end
        check_idle("single_toggle_idle", 8, 16'h0002);
    endtask

    task automatic test_double_toggle();
        do_reset();
        req_m = 1'b1;
        io64  = 16'h8011;
        tick();
        run_frame(8'h11, 5, 16'h0011, 20, 16'h8011);
        n_checks++;
        if (io65[15] !== 1'b1) begin
            n_fail++;
            $display("FAIL double_toggle_ack: got %b expected 1", io65[15]);
        end
        check_idle("double_toggle_idle", 16, 16'h8001);
    endtask

    task automatic test_reset_midframe();
        req_m = 1'b0;
        io64  = 16'h00A5;
        tick();
        for (int i = 0; i < 17; i++) tick();
        n_checks++;
        if (io65[14] !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_busy: got %b expected 1", io65[14]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (txd !== 1'b1 || io65 !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset: got txd=%b io65=%h expected txd=1 io65=0000", txd, io65);
        end
        io64 = 16'h0000;
        tick();
        tick();
        rst     = 1'b0;
        req_m   = 1'b0;
        ack_m   = 1'b0;
        count_m = 8'd0;
        check_idle("after_abort_idle", 8, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [7:0] data;
        logic [6:0] junk;
        int         mid;
        for (int k = 0; k < 256; k++) begin
            data  = 8'($urandom_range(0, 255));
            junk  = 7'($urandom_range(0, 127));
            mid   = $urandom_range(1, 10 * CPB - 1);
            req_m = ~req_m;
            io64  = {req_m, junk, data};
            tick();
            run_frame(data, mid, {req_m, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))},
                      -1, 16'h0000);
        end
        n_checks++;
        if (io65 !== 16'h0000 || io65[15] !== io64[15]) begin
            n_fail++;
            $display("FAIL count_wrap: got io65=%h req=%b expected io65=0000 with ack==req",
                     io65, io64[15]);
        end
        check_idle("final_idle", 6, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_single_toggle();
        test_double_toggle();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
